// File: rtl/slc3_mem_pkg.sv
// Shared types and the boot program image for the SLC-3 SRAM model.
// The image is a short loop; words beyond IMAGE_LEN load as zero.
package slc3_mem_pkg;

  localparam int DATA_W    = 16;
  localparam int IMAGE_LEN = 4;

  typedef enum logic {INIT, RUN} boot_state_t;

  localparam logic [DATA_W-1:0] PROG_IMAGE [IMAGE_LEN] = '{
    16'h5020, 16'h1025, 16'h3003, 16'h0FFD
  };

  function automatic logic [DATA_W-1:0] prog_word(input logic [15:0] idx);
    logic [1:0] sel;
    sel = idx[1:0];
    if (idx < 16'(IMAGE_LEN)) return PROG_IMAGE[sel];
    else                      return '0;
  endfunction

endpackage

// File: rtl/slc3_boot_loader.sv
// Boot sequencer: walks cnt over the program image after reset and
// presents one image word per cycle for the RAM write port.
//
//   state | meaning
//   ------+---------------------------------------------------
//   INIT  | copying PROG_IMAGE[cnt] into mem[cnt], CPU ignored
//   RUN   | image loaded, init_done high, CPU owns the RAM
module slc3_boot_loader
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int PROG_WORDS = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  output logic              load_we,
  output logic [ADDR_W-1:0] load_addr,
  output logic [DATA_W-1:0] load_data,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(PROG_WORDS - 1);

  boot_state_t       state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      if (cnt == LAST_CNT) begin
        state     <= RUN;
        init_done <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Reset wins over the load so a reset edge never writes the RAM.
  assign load_we   = (state == INIT) && !Reset;
  assign load_addr = cnt;
  assign load_data = prog_word(16'(cnt));

endmodule

// File: rtl/slc3_sram_model.sv
// Synchronous 16-bit SRAM with boot loader, sitting on the SLC-3 memory port.
// Optional SRAM_WPROTECT_EN blocks CPU writes into the loaded image region.
module slc3_sram_model
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int PROG_WORDS = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       ADDR,
  input  logic [DATA_W-1:0] Data_to_SRAM,
  output logic [DATA_W-1:0] Data_from_SRAM,
  output logic              init_done
`ifdef SRAM_WPROTECT_EN
  ,
  output logic              wp_violation
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_wr;
  logic              cpu_rd;
  logic              wr_allowed;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              unused_addr_hi;

  slc3_boot_loader #(
    .ADDR_W     (ADDR_W),
    .PROG_WORDS (PROG_WORDS)
  ) u_boot (
    .Clk       (Clk),
    .Reset     (Reset),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .init_done (init_done)
  );

  // Upper address bits alias; they are intentionally dropped.
  assign cpu_addr       = ADDR[ADDR_W-1:0];
  assign unused_addr_hi = ^ADDR[15:ADDR_W];

  assign cpu_wr = init_done && !Reset && !WE;
  assign cpu_rd = init_done && !OE && WE;

`ifdef SRAM_WPROTECT_EN
  logic wp_hit;
  assign wp_hit     = cpu_wr && ({1'b0, cpu_addr} < (ADDR_W+1)'(PROG_WORDS));
  assign wr_allowed = !wp_hit;

  always_ff @(posedge Clk) begin
    if (Reset)       wp_violation <= 1'b0;
    else if (wp_hit) wp_violation <= 1'b1;
  end
`else
  assign wr_allowed = 1'b1;
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = Data_to_SRAM;
    if (load_we) begin
      mem_we    = 1'b1;
      mem_addr  = load_addr;
      mem_wdata = load_data;
    end else if (cpu_wr && wr_allowed) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge Clk) begin
    if (Reset)       Data_from_SRAM <= '0;
    else if (cpu_rd) Data_from_SRAM <= mem[cpu_addr];
  end

endmodule

// File: tb/tb_slc3_sram_model.sv
// Scoreboard bench for slc3_sram_model: stimulus queues expectations,
// a monitor pops and compares them one edge later. Honors SRAM_WPROTECT_EN.
module tb_slc3_sram_model;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        OE = 1'b1;
  logic        WE = 1'b1;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] Data_to_SRAM = 16'h0000;
  logic [15:0] Data_from_SRAM;
  logic        init_done;
`ifdef SRAM_WPROTECT_EN
  logic        wp_violation;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;   // 0 = data, 1 = init_done, 2 = wp_violation
    logic [15:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt = 0;

  slc3_sram_model #(.ADDR_W(10), .PROG_WORDS(16)) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .OE             (OE),
    .WE             (WE),
    .ADDR           (ADDR),
    .Data_to_SRAM   (Data_to_SRAM),
    .Data_from_SRAM (Data_from_SRAM),
    .init_done      (init_done)
`ifdef SRAM_WPROTECT_EN
    ,
    .wp_violation   (wp_violation)
`endif
  );

  always #5 Clk = ~Clk;

  // Monitor: entries queued for an edge are compared 1 ns after that edge.
  initial begin
    int n;
    exp_t e;
    logic [15:0] act;
    forever begin
      @(posedge Clk);
      n = chk_cnt;
      #1;
      for (int i = 0; i < n; i++) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_underflow: actual empty queue, required %0d entries", n);
        end else begin
          e = exp_q.pop_front();
          act = 16'h0;
          case (e.kind)
            0: act = Data_from_SRAM;
            1: act = {15'h0, init_done};
`ifdef SRAM_WPROTECT_EN
            2: act = {15'h0, wp_violation};
`endif
            default: act = 16'hxxxx;
          endcase
          if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: actual %h, required %h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  task automatic drive(input logic rst, input logic oe, input logic we,
                       input logic [15:0] addr, input logic [15:0] din);
    @(negedge Clk);
    Reset        = rst;
    OE           = oe;
    WE           = we;
    ADDR         = addr;
    Data_to_SRAM = din;
    chk_cnt      = 0;
  endtask

  task automatic expect_val(input string nm, input int kind, input logic [15:0] exp);
    exp_t e;
    e.name = nm;
    e.kind = kind;
    e.exp  = exp;
    exp_q.push_back(e);
    chk_cnt++;
  endtask

  task automatic rd(input string nm, input logic [15:0] addr, input logic [15:0] exp);
    drive(1'b0, 1'b0, 1'b1, addr, 16'h0000);
    expect_val(nm, 0, exp);
  endtask

  task automatic wr(input string nm, input logic [15:0] addr, input logic [15:0] din,
                    input logic [15:0] held);
    drive(1'b0, 1'b1, 1'b0, addr, din);
    expect_val(nm, 0, held);
  endtask

  task automatic wait_init(input string nm);
    int n;
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge Clk);
      #1;
      if (init_done) begin
        seen = 1'b1;
        n = k;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: actual init_done=0 after 40 edges, required 1", nm);
    end else if (n != 16) begin
      errors++;
      $display("FAIL %s_edges: actual %0d edges, required 16", nm, n);
    end
  endtask

  initial begin
    // 1. Reset two cycles, then the 16-edge boot load with CPU reads ignored.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
      expect_val("reset_data", 0, 16'h0000);
      expect_val("reset_init_done", 1, 16'h0000);
    end
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
      expect_val("init_data", 0, 16'h0000);
      expect_val("init_done_edge", 1, (k == 16) ? 16'h0001 : 16'h0000);
    end

    // 2. Image readback, one-cycle latency.
    rd("rd_img0", 16'h0000, 16'h5020);
    rd("rd_img3", 16'h0003, 16'h0FFD);
    rd("rd_img1", 16'h0001, 16'h1025);
    rd("rd_img2", 16'h0002, 16'h3003);
    rd("rd_img_tail", 16'h0005, 16'h0000);

    // 3. Write then read; OE/WE both low is a write that holds the output.
    wr("wr_40_hold", 16'h0040, 16'hBEEF, 16'h0000);
    rd("rd_40", 16'h0040, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b0, 16'h0042, 16'h5555);
    expect_val("oe_we_low_hold", 0, 16'hBEEF);
    rd("rd_42", 16'h0042, 16'h5555);
    drive(1'b0, 1'b1, 1'b1, 16'h0040, 16'h0000);
    expect_val("idle_hold", 0, 16'h5555);

    // 4. Aliasing through the low 10 address bits.
    wr("wr_41_hold", 16'h0041, 16'h1234, 16'h5555);
    rd("rd_441_alias", 16'h0441, 16'h1234);
    rd("rd_400_alias", 16'h0400, 16'h5020);

    // 5. Overwrite image word, reset mid-run, image reloaded, other data kept.
`ifdef SRAM_WPROTECT_EN
    wr("wr_01_hold", 16'h0001, 16'hAAAA, 16'h5020);
    expect_val("wp_set_on_01", 2, 16'h0001);
    rd("rd_01_protected", 16'h0001, 16'h1025);
`else
    wr("wr_01_hold", 16'h0001, 16'hAAAA, 16'h5020);
    rd("rd_01_written", 16'h0001, 16'hAAAA);
`endif
    drive(1'b1, 1'b1, 1'b0, 16'h0001, 16'h7777);
    expect_val("midrun_reset_data", 0, 16'h0000);
    expect_val("midrun_reset_init_done", 1, 16'h0000);
`ifdef SRAM_WPROTECT_EN
    expect_val("midrun_reset_wp", 2, 16'h0000);
`endif
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    wait_init("reboot");
    rd("rd_01_reloaded", 16'h0001, 16'h1025);
    rd("rd_40_retained", 16'h0040, 16'hBEEF);
    rd("rd_41_retained", 16'h0041, 16'h1234);

    // 6. Write protection of the image region, or plain writes without it.
`ifdef SRAM_WPROTECT_EN
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    expect_val("wp_clear_after_boot", 2, 16'h0000);
    wr("wr_02_hold", 16'h0002, 16'hFFFF, 16'h1234);
    expect_val("wp_set_on_02", 2, 16'h0001);
    rd("rd_02_protected", 16'h0002, 16'h3003);
    wr("wr_0f_hold", 16'h040F, 16'h9999, 16'h3003);
    rd("rd_0f_protected", 16'h000F, 16'h0000);
    wr("wr_10_hold", 16'h0010, 16'h7777, 16'h0000);
    rd("rd_10_written", 16'h0010, 16'h7777);
    expect_val("wp_sticky", 2, 16'h0001);
    drive(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    expect_val("wp_reset", 2, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    wait_init("reboot_wp");
`else
    wr("wr_02_hold", 16'h0002, 16'hFFFF, 16'h1234);
    rd("rd_02_written", 16'h0002, 16'hFFFF);
    wr("wr_10_hold", 16'h0010, 16'h7777, 16'hFFFF);
    rd("rd_10_written", 16'h0010, 16'h7777);
`endif

    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    drive(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
    @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_sram_model.md
Name: slc3_sram_model

Overview:
Synchronous SRAM model with built-in boot loader. It sits directly downstream of the SLC-3 core's memory port: it consumes ADDR, Data_to_SRAM, OE and WE, and produces Data_from_SRAM. After reset it copies a fixed program image into RAM, then serves CPU reads and writes. It is instantiated inside slc3_testtop so the core runs a known program in simulation and on the FPGA without external SRAM.

Parameters:
ADDR_W, 10, RAM address width; depth = 2**ADDR_W words of 16 bits
PROG_WORDS, 16, number of program-image words copied at boot; must satisfy 1 <= PROG_WORDS <= 2**ADDR_W

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset; restarts the boot load
OE  input  1  output enable, active-low
WE  input  1  write enable, active-low
ADDR  input  16  word address from MAR; only ADDR[ADDR_W-1:0] is used
Data_to_SRAM  input  16  write data from MDR
Data_from_SRAM  output  16  registered read data
init_done  output  1  high once the boot load is complete
wp_violation  output  1  sticky write-protect flag; exists only with SRAM_WPROTECT_EN

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high. All state changes on the Clk rising edge only.
- Reset (Reset sampled high), which overrides everything:
  - FSM = INIT, load counter cnt = 0
  - Data_from_SRAM = 16'h0000, init_done = 0, wp_violation = 0
  - RAM contents are not cleared.
- State INIT:
  - Each edge with Reset low writes mem[cnt] = PROG_IMAGE[cnt].
  - If cnt == PROG_WORDS-1: next state = RUN and init_done <= 1. Otherwise cnt <= cnt+1.
  - init_done therefore rises on the PROG_WORDS-th edge after Reset is released.
  - CPU OE/WE are ignored and Data_from_SRAM holds 0.
- State RUN (init_done = 1):
  - Read, when OE=0 and WE=1: Data_from_SRAM <= mem[ADDR[ADDR_W-1:0]]. Latency is exactly 1 cycle, which fits inside the core's MDR wait states.
  - Write, when WE=0: mem[ADDR[ADDR_W-1:0]] <= Data_to_SRAM. Data_from_SRAM holds its previous value. WE=0 wins over OE=0.
  - Idle, when OE=1 and WE=1: Data_from_SRAM holds its value.
  - Read-after-write to the same address on the next cycle returns the new data.
- Addressing: addresses >= 2**ADDR_W alias through the low ADDR_W bits. For example, with ADDR_W=10, 16'h0400 maps to word 0.
- Reset mid-load or mid-run: the FSM returns to INIT and the image is reloaded. Image words overwrite any CPU data at 0..PROG_WORDS-1; other words are kept.
- Words at PROG_WORDS and above are undefined until written. The bench must not read them first.

Optional Feature:
Macro SRAM_WPROTECT_EN.
- Defined:
  - In RUN, writes with ADDR[ADDR_W-1:0] < PROG_WORDS are discarded (mem unchanged).
  - wp_violation is set to 1 on the edge of the offending write and stays 1 until Reset.
  - Boot-load writes are never blocked.
- Undefined: the wp_violation port is absent and all RUN writes are performed.

Decomposition:
- Package slc3_mem_pkg:
  - typedef enum logic {INIT, RUN} boot_state_t
  - PROG_IMAGE constant array of 16-bit words: [0]=16'h5020, [1]=16'h1025, [2]=16'h3003, [3]=16'h0FFD; remaining words 16'h0000.
  - DATA_W=16
- Sub-module slc3_boot_loader: owns boot_state_t, cnt and init_done. It outputs load_we, load_addr and load_data, which slc3_sram_model muxes ahead of the CPU port.

Test Plan:
1. Reset high for 2 cycles, then low; PROG_WORDS=16 -> init_done=0 for 15 edges and 1 after the 16th. Data_from_SRAM=0 throughout INIT.
2. After init_done, OE=0, WE=1, ADDR=16'h0000, then 16'h0003 -> Data_from_SRAM = 16'h5020, then 16'h0FFD, each one cycle after the address is presented.
3. WE=0, ADDR=16'h0040, Data_to_SRAM=16'hBEEF, then read 16'h0040 next cycle -> 16'hBEEF. Also: a cycle with OE=0 and WE=0 leaves Data_from_SRAM unchanged.
4. Write 16'h1234 to 16'h0041, then read 16'h0441 (ADDR_W=10) -> 16'h1234 (aliasing).
5. Write 16'hAAAA to 16'h0001, pulse Reset mid-RUN, wait for init_done, then read 16'h0001 -> 16'h1025. Read 16'h0040 -> 16'hBEEF (retained).
6. With SRAM_WPROTECT_EN: write 16'hFFFF to 16'h0002 -> read still gives 16'h3003 and wp_violation=1 until Reset. Write to 16'h0010 succeeds.
